// File: rtl/id_issue_bypass.sv
// Decode/issue stage: register-file read, multi-producer operand bypass with
// per-producer data-ready, hazard stall, registered issue to EX with flush.
module id_issue_bypass #(
    parameter int                 DATA_W    = 32,
    parameter int                 REG_AW    = 5,
    parameter int                 NUM_FWD   = 3,
    parameter int                 PAYLOAD_W = 64,
    parameter int                 CNT_W     = 16,
    parameter logic [DATA_W-1:0]  PC_RESET  = 32'h1c000000
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        flush,
    input  logic [DATA_W-1:0]           in_pc,
    input  logic [PAYLOAD_W-1:0]        in_payload,
    input  logic [REG_AW-1:0]           in_src1_addr,
    input  logic [REG_AW-1:0]           in_src2_addr,
    input  logic                        in_src1_en,
    input  logic                        in_src2_en,
    input  logic [REG_AW-1:0]           in_dest,
    input  logic                        in_gr_we,
    output logic [REG_AW-1:0]           rf_raddr1,
    output logic [REG_AW-1:0]           rf_raddr2,
    input  logic [DATA_W-1:0]           rf_rdata1,
    input  logic [DATA_W-1:0]           rf_rdata2,
    input  logic [NUM_FWD-1:0]          fwd_valid,
    input  logic [NUM_FWD-1:0]          fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0]   fwd_dest,
    input  logic [NUM_FWD-1:0]          fwd_data_ok,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
    output logic [DATA_W-1:0]           out_pc,
    output logic [PAYLOAD_W-1:0]        out_payload,
    output logic [DATA_W-1:0]           out_src1,
    output logic [DATA_W-1:0]           out_src2,
    output logic [REG_AW-1:0]           out_dest,
    output logic                        out_gr_we,
    output logic                        hazard_stall,
    output logic [CNT_W-1:0]            stall_cnt,
    input  logic                        stall_cnt_clr
);

    // Returns {unresolved, value}. Scanning oldest to youngest lets the
    // youngest matching producer overwrite, so older matches never leak through.
    function automatic logic [DATA_W:0] resolve_src(
        input logic [REG_AW-1:0]         addr,
        input logic [DATA_W-1:0]         rf_data,
        input logic [NUM_FWD-1:0]        f_valid,
        input logic [NUM_FWD-1:0]        f_we,
        input logic [NUM_FWD-1:0]        f_ok,
        input logic [NUM_FWD*REG_AW-1:0] f_dest,
        input logic [NUM_FWD*DATA_W-1:0] f_data
    );
        logic [DATA_W:0] res;
        res = {1'b0, rf_data};
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (f_valid[i] && f_we[i] && (f_dest[i*REG_AW +: REG_AW] == addr)) begin
                res = {~f_ok[i], f_data[i*DATA_W +: DATA_W]};
            end else begin
                res = res;
            end
        end
        if (addr == {REG_AW{1'b0}}) begin
            res = {(DATA_W+1){1'b0}};
        end else begin
            res = res;
        end
        return res;
    endfunction

    logic [DATA_W:0]     res1_s;
    logic [DATA_W:0]     res2_s;
    logic                unres1_s;
    logic                unres2_s;
    logic                hazard_s;
    logic                out_free_s;
    logic                accept_s;

    logic                out_valid_r;
    logic [DATA_W-1:0]   out_pc_r;
    logic [PAYLOAD_W-1:0] out_payload_r;
    logic [DATA_W-1:0]   out_src1_r;
    logic [DATA_W-1:0]   out_src2_r;
    logic [REG_AW-1:0]   out_dest_r;
    logic                out_gr_we_r;
    logic [CNT_W-1:0]    stall_cnt_r;

    assign res1_s = resolve_src(in_src1_addr, rf_rdata1, fwd_valid, fwd_we,
                                fwd_data_ok, fwd_dest, fwd_data);
    assign res2_s = resolve_src(in_src2_addr, rf_rdata2, fwd_valid, fwd_we,
                                fwd_data_ok, fwd_dest, fwd_data);

    assign unres1_s   = res1_s[DATA_W] & in_src1_en;
    assign unres2_s   = res2_s[DATA_W] & in_src2_en;
    assign hazard_s   = in_valid & (unres1_s | unres2_s);
    assign out_free_s = ~out_valid_r | out_ready;
    assign accept_s   = in_valid & ~hazard_s & out_free_s & ~flush;

    assign rf_raddr1    = in_src1_addr;
    assign rf_raddr2    = in_src2_addr;
    assign hazard_stall = hazard_s;
    assign in_ready     = flush | ~in_valid | (~hazard_s & out_free_s);

    assign out_valid   = out_valid_r;
    assign out_pc      = out_pc_r;
    assign out_payload = out_payload_r;
    assign out_src1    = out_src1_r;
    assign out_src2    = out_src2_r;
    assign out_dest    = out_dest_r;
    assign out_gr_we   = out_gr_we_r;
    assign stall_cnt   = stall_cnt_r;

    // Output valid: flush kills, a free slot takes the accept, otherwise hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (out_free_s) begin
            out_valid_r <= accept_s;
        end
    end

    // Issue data registers load only on accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_pc_r      <= PC_RESET;
            out_payload_r <= {PAYLOAD_W{1'b0}};
            out_src1_r    <= {DATA_W{1'b0}};
            out_src2_r    <= {DATA_W{1'b0}};
            out_dest_r    <= {REG_AW{1'b0}};
            out_gr_we_r   <= 1'b0;
        end else if (accept_s) begin
            out_pc_r      <= in_pc;
            out_payload_r <= in_payload;
            out_src1_r    <= res1_s[DATA_W-1:0];
            out_src2_r    <= res2_s[DATA_W-1:0];
            out_dest_r    <= in_dest;
            out_gr_we_r   <= in_gr_we;
        end
    end

    // Saturating hazard-stall counter; flushed cycles are not stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_cnt_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (hazard_s && !flush && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_issue_bypass.sv
// Directed bench for id_issue_bypass: bypass priority, load-use stall,
// r0/disabled sources, backpressure, flush, counter saturation and async reset.
module tb_id_issue_bypass;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NF = 3;
    localparam int PW = 64;
    localparam int CW = 2;
    localparam logic [31:0] PC_RST = 32'h1c000000;

    logic           clk;
    logic           resetn;
    logic           in_valid;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic           flush;
    logic [DW-1:0]  in_pc;
    logic [PW-1:0]  in_payload;
    logic [AW-1:0]  in_src1_addr;
    logic [AW-1:0]  in_src2_addr;
    logic           in_src1_en;
    logic           in_src2_en;
    logic [AW-1:0]  in_dest;
    logic           in_gr_we;
    logic [AW-1:0]  rf_raddr1;
    logic [AW-1:0]  rf_raddr2;
    logic [DW-1:0]  rf_rdata1;
    logic [DW-1:0]  rf_rdata2;
    logic [NF-1:0]  fwd_valid;
    logic [NF-1:0]  fwd_we;
    logic [NF*AW-1:0] fwd_dest;
    logic [NF-1:0]  fwd_data_ok;
    logic [NF*DW-1:0] fwd_data;
    logic [DW-1:0]  out_pc;
    logic [PW-1:0]  out_payload;
    logic [DW-1:0]  out_src1;
    logic [DW-1:0]  out_src2;
    logic [AW-1:0]  out_dest;
    logic           out_gr_we;
    logic           hazard_stall;
    logic [CW-1:0]  stall_cnt;
    logic           stall_cnt_clr;

    int n_chk;
    int n_pass;

    id_issue_bypass #(
        .DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF), .PAYLOAD_W(PW),
        .CNT_W(CW), .PC_RESET(PC_RST)
    ) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .in_pc(in_pc), .in_payload(in_payload),
        .in_src1_addr(in_src1_addr), .in_src2_addr(in_src2_addr),
        .in_src1_en(in_src1_en), .in_src2_en(in_src2_en),
        .in_dest(in_dest), .in_gr_we(in_gr_we),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_dest(fwd_dest),
        .fwd_data_ok(fwd_data_ok), .fwd_data(fwd_data),
        .out_pc(out_pc), .out_payload(out_payload),
        .out_src1(out_src1), .out_src2(out_src2),
        .out_dest(out_dest), .out_gr_we(out_gr_we),
        .hazard_stall(hazard_stall), .stall_cnt(stall_cnt),
        .stall_cnt_clr(stall_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fwd();
        fwd_valid   = '0;
        fwd_we      = '0;
        fwd_dest    = '0;
        fwd_data_ok = '0;
        fwd_data    = '0;
    endtask

    task automatic set_fwd(input int p, input logic [4:0] d, input logic ok, input logic [31:0] data);
        fwd_valid[p]          = 1'b1;
        fwd_we[p]             = 1'b1;
        fwd_dest[p*AW +: AW]  = d;
        fwd_data_ok[p]        = ok;
        fwd_data[p*DW +: DW]  = data;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        resetn = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; stall_cnt_clr = 1'b0;
        in_pc = 32'h0; in_payload = 64'h0;
        in_src1_addr = 5'd0; in_src2_addr = 5'd0;
        in_src1_en = 1'b0; in_src2_en = 1'b0;
        in_dest = 5'd0; in_gr_we = 1'b0;
        rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
        clr_fwd();

        // reset state
        tick();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_pc", 64'(out_pc), 64'h1c000000);
        check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        check("rst_out_src1", 64'(out_src1), 64'h0);
        resetn = 1'b1;
        tick();

        // no hazard: register-file operand
        in_valid = 1'b1; in_pc = 32'h100; in_payload = 64'hdeadbeef_cafef00d;
        in_src1_addr = 5'd4; in_src1_en = 1'b1; rf_rdata1 = 32'h11;
        in_src2_addr = 5'd6; in_src2_en = 1'b1; rf_rdata2 = 32'h66;
        in_dest = 5'd7; in_gr_we = 1'b1;
        #1;
        check("nohaz_raddr1", 64'(rf_raddr1), 64'd4);
        check("nohaz_raddr2", 64'(rf_raddr2), 64'd6);
        check("nohaz_hazard", 64'(hazard_stall), 64'h0);
        check("nohaz_in_ready", 64'(in_ready), 64'h1);
        tick();
        check("nohaz_out_valid", 64'(out_valid), 64'h1);
        check("nohaz_src1", 64'(out_src1), 64'h11);
        check("nohaz_src2", 64'(out_src2), 64'h66);
        check("nohaz_pc", 64'(out_pc), 64'h100);
        check("nohaz_payload", out_payload, 64'hdeadbeef_cafef00d);
        check("nohaz_dest", 64'(out_dest), 64'd7);
        check("nohaz_gr_we", 64'(out_gr_we), 64'h1);

        // priority: youngest matching port wins
        in_pc = 32'h104;
        set_fwd(0, 5'd4, 1'b1, 32'hAA);
        set_fwd(2, 5'd4, 1'b1, 32'hBB);
        tick();
        check("prio_port0", 64'(out_src1), 64'hAA);
        fwd_valid[0] = 1'b0;
        in_pc = 32'h108;
        tick();
        check("prio_port2", 64'(out_src1), 64'hBB);
        check("prio_pc", 64'(out_pc), 64'h108);

        // load-use stall for two cycles
        clr_fwd();
        set_fwd(0, 5'd4, 1'b0, 32'h99);
        set_fwd(1, 5'd4, 1'b1, 32'h77);
        in_pc = 32'h10c;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("lu_hazard", 64'(hazard_stall), 64'h1);
            check("lu_in_ready", 64'(in_ready), 64'h0);
            tick();
            check("lu_out_valid", 64'(out_valid), 64'h0);
        end
        check("lu_stall_cnt", 64'(stall_cnt), 64'd2);
        fwd_data_ok[0] = 1'b1;
        fwd_data[0 +: DW] = 32'hCC;
        #1;
        check("lu_go_ready", 64'(in_ready), 64'h1);
        tick();
        check("lu_issue_valid", 64'(out_valid), 64'h1);
        check("lu_issue_src1", 64'(out_src1), 64'hCC);
        check("lu_cnt_hold", 64'(stall_cnt), 64'd2);

        // r0 source never stalls and reads as zero
        clr_fwd();
        set_fwd(0, 5'd0, 1'b0, 32'h55);
        in_src1_addr = 5'd0; rf_rdata1 = 32'h1234;
        in_pc = 32'h110;
        #1;
        check("r0_hazard", 64'(hazard_stall), 64'h0);
        tick();
        check("r0_src1", 64'(out_src1), 64'h0);

        // disabled source with unresolved match does not stall
        clr_fwd();
        set_fwd(1, 5'd5, 1'b0, 32'h88);
        in_src1_addr = 5'd4; rf_rdata1 = 32'h22;
        in_src2_addr = 5'd5; in_src2_en = 1'b0;
        in_pc = 32'h114;
        #1;
        check("dis_hazard", 64'(hazard_stall), 64'h0);
        check("dis_in_ready", 64'(in_ready), 64'h1);
        tick();
        check("dis_src1", 64'(out_src1), 64'h22);
        check("dis_pc", 64'(out_pc), 64'h114);

        // backpressure holds the output register
        clr_fwd();
        in_src2_en = 1'b1; in_src2_addr = 5'd6;
        in_pc = 32'h200; rf_rdata1 = 32'h33;
        tick();
        check("bp_load_pc", 64'(out_pc), 64'h200);
        out_ready = 1'b0;
        in_pc = 32'h300; rf_rdata1 = 32'h44;
        #1;
        check("bp_in_ready", 64'(in_ready), 64'h0);
        tick();
        check("bp_valid_hold", 64'(out_valid), 64'h1);
        check("bp_pc_hold", 64'(out_pc), 64'h200);
        check("bp_src1_hold", 64'(out_src1), 64'h33);

        // flush with a concurrent hazard: discard, not counted
        set_fwd(0, 5'd4, 1'b0, 32'h0);
        flush = 1'b1;
        #1;
        check("fl_hazard", 64'(hazard_stall), 64'h1);
        check("fl_in_ready", 64'(in_ready), 64'h1);
        tick();
        check("fl_out_valid", 64'(out_valid), 64'h0);
        check("fl_stall_cnt", 64'(stall_cnt), 64'd2);
        flush = 1'b0;
        out_ready = 1'b1;

        // clear, saturate, clear wins over increment
        in_valid = 1'b0;
        stall_cnt_clr = 1'b1;
        tick();
        check("clr_cnt", 64'(stall_cnt), 64'd0);
        stall_cnt_clr = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        check("sat_cnt", 64'(stall_cnt), 64'd3);
        check("sat_out_valid", 64'(out_valid), 64'h0);
        stall_cnt_clr = 1'b1;
        tick();
        check("clr_prio_cnt", 64'(stall_cnt), 64'd0);
        stall_cnt_clr = 1'b0;

        // async reset mid-stall
        clr_fwd();
        out_ready = 1'b0;
        in_pc = 32'h400; rf_rdata1 = 32'h77;
        tick();
        check("ar_pre_valid", 64'(out_valid), 64'h1);
        set_fwd(0, 5'd4, 1'b0, 32'h0);
        tick();
        tick();
        check("ar_pre_cnt", 64'(stall_cnt), 64'd2);
        #3;
        resetn = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'h0);
        check("ar_out_pc", 64'(out_pc), 64'h1c000000);
        check("ar_stall_cnt", 64'(stall_cnt), 64'd0);
        check("ar_out_src1", 64'(out_src1), 64'h0);
        check("ar_out_payload", out_payload, 64'h0);
        check("ar_out_dest_we", 64'({out_dest, out_gr_we}), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
